// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared defaults and stage-count helper for the chunked pipelined adder
package pipelined_adder_pkg;
    localparam int N_DEFAULT = 8;
    localparam int K_DEFAULT = 4;
    function automatic int num_stages(input int n, input int k);
        return n / k;
    endfunction
endpackage

// File: rtl/pipelined_adder_chunk.sv
// adder_chunk: K-bit combinational ripple add exposing carry-out and the carry into its MSB
module adder_chunk import pipelined_adder_pkg::*; #(
    parameter int K = K_DEFAULT
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         ci,
    output logic [K-1:0] s,
    output logic         co,
    output logic         c_msb
);
    logic [K:0] c;
    always_comb begin
        c = '0;
        c[0] = ci;
        for (int i = 0; i < K; i++) c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
    end
    assign s = a ^ b ^ c[K-1:0];
    assign co = c[K];
    assign c_msb = c[K-1];
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: N-bit add/subtract split into K-bit ripple stages with input skew,
// output deskew and a valid/ready handshake that freezes the whole pipeline on stall.
module pipelined_adder import pipelined_adder_pkg::*; #(
    parameter int N = N_DEFAULT,
    parameter int K = K_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         Cin,
    input  logic         sub,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] s,
    output logic         Cout,
    output logic         ovf,
    output logic         out_valid,
    input  logic         out_ready
);
    localparam int L = num_stages(N, K);
    if (K < 1 || K > N || N % K != 0) begin : g_bad
        $error("pipelined_adder: N must be a positive multiple of K");
    end
    logic [N-1:0] ym;
    logic [L-1:0] v, cr;
    logic         c0, mr;
    // Subtraction is x + ~y + 1: invert y once before it is skewed
    assign ym = sub ? ~y : y;
    assign c0 = sub | Cin;
    assign in_ready = ~(out_valid & ~out_ready);
    assign out_valid = v[L-1];
    assign Cout = cr[L-1];
    assign ovf = mr ^ Cout;
    for (genvar j = 0; j < L; j++) begin : g_stage
        logic [K-1:0]            xo, yo, so;
        logic [L-1-j:0][K-1:0]   d;
        logic                    ci, co, vin;
        if (j == 0) begin : g_first
            assign xo = x[K-1:0];
            assign yo = ym[K-1:0];
            assign ci = c0;
            assign vin = in_valid;
        end else begin : g_skew
            logic [j-1:0][K-1:0] xr, yr;
            always_ff @(posedge clk)
                if (rst) begin
                    xr <= '0;
                    yr <= '0;
                end else if (in_ready) begin
                    xr[0] <= x[j*K +: K];
                    yr[0] <= ym[j*K +: K];
                    for (int i = 1; i < j; i++) begin
                        xr[i] <= xr[i-1];
                        yr[i] <= yr[i-1];
                    end
                end
            assign xo = xr[j-1];
            assign yo = yr[j-1];
            assign ci = cr[j-1];
            assign vin = v[j-1];
        end
        always_ff @(posedge clk)
            if (rst) begin
                v[j] <= 1'b0;
                cr[j] <= 1'b0;
                d <= '0;
            end else if (in_ready) begin
                v[j] <= vin;
                cr[j] <= co;
                d[0] <= so;
                for (int i = 1; i < L - j; i++) d[i] <= d[i-1];
            end
        assign s[j*K +: K] = d[L-1-j];
        if (j == L - 1) begin : g_last
            logic cm;
            adder_chunk #(.K(K)) u_add (.a(xo), .b(yo), .ci(ci), .s(so), .co(co), .c_msb(cm));
            always_ff @(posedge clk)
                if (rst) mr <= 1'b0;
                else if (in_ready) mr <= cm;
        end else begin : g_mid
            logic cm_unused;
            adder_chunk #(.K(K)) u_add (.a(xo), .b(yo), .ci(ci), .s(so), .co(co), .c_msb(cm_unused));
        end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed vectors and handshake sequences on N=8/K=4, randomized
// add/sub with random backpressure on N=8/K=4, N=16/K=4 and N=8/K=8 against an arithmetic model.
module tb_pipelined_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] x[3], y[3], so[3];
    logic [2:0]  cin, sb, iv, ordy, ir, ov, co, of;
    logic [7:0]  s0, s2;
    logic [15:0] s1;
    int total = 0, bad = 0;

    pipelined_adder #(.N(8), .K(4)) u0 (.clk(clk), .rst(rst), .x(x[0][7:0]), .y(y[0][7:0]),
        .Cin(cin[0]), .sub(sb[0]), .in_valid(iv[0]), .in_ready(ir[0]), .s(s0), .Cout(co[0]),
        .ovf(of[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
    pipelined_adder #(.N(16), .K(4)) u1 (.clk(clk), .rst(rst), .x(x[1]), .y(y[1]),
        .Cin(cin[1]), .sub(sb[1]), .in_valid(iv[1]), .in_ready(ir[1]), .s(s1), .Cout(co[1]),
        .ovf(of[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
    pipelined_adder #(.N(8), .K(8)) u2 (.clk(clk), .rst(rst), .x(x[2][7:0]), .y(y[2][7:0]),
        .Cin(cin[2]), .sub(sb[2]), .in_valid(iv[2]), .in_ready(ir[2]), .s(s2), .Cout(co[2]),
        .ovf(of[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

    assign so[0] = {8'h00, s0};
    assign so[1] = s1;
    assign so[2] = {8'h00, s2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: unsigned sum/difference for s and Cout, signed range test for ovf
    function automatic logic [17:0] model(input int n, input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic m);
        longint ua = a, ub = b, cc = c, lim, sa, sbv, r, sum;
        logic cout;
        lim = longint'(1) << (n - 1);
        sa = (ua >= lim) ? ua - 2 * lim : ua;
        sbv = (ub >= lim) ? ub - 2 * lim : ub;
        if (m) begin
            sum = ua - ub;
            cout = ua >= ub;
            r = sa - sbv;
        end else begin
            sum = ua + ub + cc;
            cout = sum >= 2 * lim;
            r = sa + sbv + cc;
        end
        return {(r < -lim || r >= lim), cout, 16'(sum & (2 * lim - 1))};
    endfunction

    task automatic run_random(input int d, input int n, input int count);
        logic [17:0] q[$];
        logic [17:0] e;
        logic [15:0] mask = 16'((32'h1 << n) - 1);
        int acc = 0, cyc = 0;
        bit hold = 0;
        while ((acc < count || q.size() > 0) && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            ordy[d] = ($urandom_range(0, 3) != 0);
            if (!hold) begin
                iv[d] = (acc < count) && ($urandom_range(0, 3) != 0);
                x[d] = 16'($urandom) & mask;
                y[d] = 16'($urandom) & mask;
                cin[d] = 1'($urandom);
                sb[d] = 1'($urandom);
            end
            #1;
            if (ov[d] && ordy[d]) begin
                if (q.size() == 0) chk($sformatf("rand%0d_extra", d), 1, 0);
                else begin
                    e = q.pop_front();
                    chk($sformatf("rand%0d_s", d), so[d], e[15:0]);
                    chk($sformatf("rand%0d_cout", d), co[d], e[16]);
                    chk($sformatf("rand%0d_ovf", d), of[d], e[17]);
                end
            end
            if (iv[d] && ir[d]) begin
                q.push_back(model(n, x[d], y[d], cin[d], sb[d]));
                acc++;
            end
            hold = iv[d] && !ir[d];
        end
        chk($sformatf("rand%0d_drain", d), q.size() + ((acc < count) ? 1 : 0), 0);
        @(negedge clk);
        iv[d] = 0;
        ordy[d] = 1;
    endtask

    typedef struct {
        logic [7:0] a, b;
        logic       c, m;
        logic [7:0] es;
        logic       ec, eo;
    } vec_t;
    vec_t tab[9];

    task automatic drive0(input logic [7:0] a, input logic [7:0] b, input logic c, input logic m);
        x[0] = {8'h00, a};
        y[0] = {8'h00, b};
        cin[0] = c;
        sb[0] = m;
        iv[0] = 1;
    endtask

    initial begin
        tab[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        tab[1] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        tab[2] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        tab[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tab[4] = '{8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
        tab[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        tab[6] = '{8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        tab[7] = '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0};
        tab[8] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            x[i] = '0;
            y[i] = '0;
        end
        cin = '0; sb = '0; iv = '0; ordy = '1;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        chk("rst_out_valid", ov[0], 0);
        chk("rst_in_ready", ir[0], 1);
        chk("rst_s", so[0], 0);
        chk("rst_cout", co[0], 0);
        chk("rst_ovf", of[0], 0);

        foreach (tab[i]) begin
            @(negedge clk);
            drive0(tab[i].a, tab[i].b, tab[i].c, tab[i].m);
            @(negedge clk);
            iv[0] = 0;
            chk($sformatf("vec%0d_early", i), ov[0], 0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), ov[0], 1);
            chk($sformatf("vec%0d_s", i), so[0], {8'h00, tab[i].es});
            chk($sformatf("vec%0d_cout", i), co[0], tab[i].ec);
            chk($sformatf("vec%0d_ovf", i), of[0], tab[i].eo);
        end

        // back-to-back 1+1, 2+2, 3+3
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 3) drive0(8'(i + 1), 8'(i + 1), 0, 0);
            else iv[0] = 0;
            if (i >= 2) begin
                chk($sformatf("b2b%0d_valid", i), ov[0], 1);
                chk($sformatf("b2b%0d_s", i), so[0], 2 * (i - 1));
            end
        end

        // two results in flight, consumer stalls 3 cycles, a held request waits
        @(negedge clk);
        drive0(8'h11, 8'h22, 0, 0);
        @(negedge clk);
        drive0(8'h03, 8'h04, 0, 0);
        @(negedge clk);
        iv[0] = 0;
        ordy[0] = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) drive0(8'h01, 8'h01, 0, 0);
            #1;
            chk($sformatf("stall%0d_in_ready", i), ir[0], 0);
            chk($sformatf("stall%0d_valid", i), ov[0], 1);
            chk($sformatf("stall%0d_s", i), so[0], 16'h33);
            @(negedge clk);
        end
        ordy[0] = 1;
        #1;
        chk("unstall_in_ready", ir[0], 1);
        chk("unstall_s", so[0], 16'h33);
        @(negedge clk);
        iv[0] = 0;
        chk("after_stall1_valid", ov[0], 1);
        chk("after_stall1_s", so[0], 16'h07);
        @(negedge clk);
        chk("after_stall2_valid", ov[0], 1);
        chk("after_stall2_s", so[0], 16'h02);
        @(negedge clk);
        chk("after_stall_idle", ov[0], 0);

        // reset kills an in-flight op and blocks one presented during reset
        @(negedge clk);
        drive0(8'h10, 8'h10, 0, 0);
        @(negedge clk);
        rst = 1;
        drive0(8'h20, 8'h20, 0, 0);
        @(negedge clk);
        rst = 0;
        iv[0] = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rst_flush%0d", i), ov[0], 0);
            @(negedge clk);
        end

        run_random(0, 8, 200);
        run_random(1, 16, 300);
        run_random(2, 8, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter N, default 8, operand/sum width in bits.
REQ-002 Parameter K, default 4, chunk width in bits; N SHALL be an integer multiple of K, with 1 <= K <= N.
REQ-003 Derived constant L = N/K, the pipeline depth in stages.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 x  input  N  operand A.
REQ-007 y  input  N  operand B.
REQ-008 Cin  input  1  carry-in; used only when sub=0.
REQ-009 sub  input  1  mode: 0 = add, 1 = subtract.
REQ-010 in_valid  input  1  x, y, Cin and sub are valid.
REQ-011 in_ready  output  1  the block accepts an operation this cycle.
REQ-012 s  output  N  sum or difference.
REQ-013 Cout  output  1  carry-out of the MSB (for subtract: 1 = no borrow).
REQ-014 ovf  output  1  signed two's-complement overflow.
REQ-015 out_valid  output  1  s, Cout and ovf are valid.
REQ-016 out_ready  input  1  the consumer accepts the result.

Function
REQ-017 An operation is accepted on a rising edge when in_valid=1 and in_ready=1.
REQ-018 A result is delivered on a rising edge when out_valid=1 and out_ready=1.
REQ-019 Add mode SHALL compute {Cout,s} = x + y + Cin, modulo 2^(N+1).
REQ-020 Subtract mode SHALL compute {Cout,s} = x + ~y + 1, with Cin ignored.
REQ-021 ovf SHALL equal the carry into bit N-1 XOR Cout.
REQ-022 Stage j (0..L-1) SHALL add chunk j of the operands, bits [jK+K-1:jK], together with the registered carry from stage j-1; stage 0 uses the mode-selected carry-in.
REQ-023 Operand chunks for stage j SHALL be delayed by j register levels (input skew).
REQ-024 Sum chunk j SHALL be delayed by L-1-j register levels (output deskew), so that all N bits of s emerge aligned.
REQ-025 Latency: a result SHALL be visible exactly L cycles after acceptance when the pipeline is not stalled; with K=N, L=1 (a single registered stage).
REQ-026 Each stage SHALL carry a valid bit, and out_valid SHALL be the valid bit of the last stage.
REQ-027 stall = out_valid AND NOT out_ready.
REQ-028 When stall=1, every pipeline register, including the valid bits, SHALL hold its value.
REQ-029 in_ready SHALL equal NOT stall; this path is combinational from out_ready.
REQ-030 Bubbles (invalid stages) SHALL advance with the pipeline and SHALL NOT be collapsed.
REQ-031 Throughput SHALL be one operation per cycle when out_ready is held at 1.
REQ-032 When in_valid=1 while stalled, the operation is not accepted; the source holds its inputs until a cycle with in_ready=1.
REQ-033 Results SHALL leave in acceptance order, with no loss or duplication across any stall pattern.

Reset
REQ-034 While rst=1 on a rising edge, all valid bits SHALL clear.
REQ-035 The cycle after reset: out_valid=0, in_ready=1, s=0, Cout=0, ovf=0; data registers clear to 0.
REQ-036 Reset applied mid-operation SHALL discard every in-flight operation, with no result emitted for any of them.
REQ-037 An operation presented during the reset cycle SHALL NOT be accepted.

Structure
REQ-038 A shared package SHALL hold the default values of N and K and a function computing L.
REQ-039 One sub-module, adder_chunk: a K-bit combinational ripple add with carry-in, carry-out and the MSB carry-in (for ovf).
REQ-040 The top level SHALL instantiate L adder_chunk instances and the skew, deskew and valid registers inside a generate loop.
REQ-041 An elaboration-time check SHALL fail when N mod K != 0.

Verification (N=8, K=4, L=2 unless stated)
REQ-042 Add x=8'hFF, y=8'h01, Cin=0, out_ready=1 -> 2 cycles later s=8'h00, Cout=1, ovf=0.
REQ-043 Subtract x=8'h80, y=8'h01 -> s=8'h7F, Cout=1, ovf=1; subtract x=8'h00, y=8'h01 -> s=8'hFF, Cout=0, ovf=0.
REQ-044 Back-to-back operations 1+1, 2+2, 3+3, one per cycle -> s=2, 4, 6 on three consecutive cycles.
REQ-045 out_ready=0 for 3 cycles while 2 results are in flight -> in_ready=0, s held stable, then both results delivered in order with no loss.
REQ-046 rst asserted one cycle after accepting 8'h10+8'h10 -> out_valid stays 0 and no 8'h20 is ever emitted.
REQ-047 Random add/sub with N=16, K=4 and N=8, K=8, with random out_ready -> every result matches the reference model, in order.
